param_stack_unit: RTL

PARAM_STACK_UNIT -- requirements
Module: param_stack_unit

---
 rtl/param_stack_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/param_stack_unit.sv
// LIFO stack with registered top-of-stack output and occupancy count.
// Define PARAM_STACK_ERR_EN to build the sticky overflow/underflow flags.
module param_stack_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stack_push,
  input  logic                  stack_pop,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  is_empty,
  output logic                  is_full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] dout_q;

  logic          empty, full;
  logic          do_push, do_pop, do_repl;
  logic          push_refused, pop_refused;
  logic [AW-1:0] idx_push, idx_top, idx_below;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // Index math wraps in AW bits; at count==DEPTH the low bits are 0 so top = DEPTH-1.
  assign idx_push  = cnt_q[AW-1:0];
  assign idx_top   = cnt_q[AW-1:0] - AW'(1);
  assign idx_below = cnt_q[AW-1:0] - AW'(2);

  // Push+pop on an empty stack degrades to a plain push.
  always_comb begin
    do_push      = 1'b0;
    do_pop       = 1'b0;
    do_repl      = 1'b0;
    push_refused = 1'b0;
    pop_refused  = 1'b0;
    if (!rst && !flush) begin
      if (stack_push && stack_pop) begin
        if (empty) do_push = 1'b1;
        else       do_repl = 1'b1;
      end else if (stack_push) begin
        if (full) push_refused = 1'b1;
        else      do_push      = 1'b1;
      end else if (stack_pop) begin
        if (empty) pop_refused = 1'b1;
        else       do_pop      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)      mem[idx_push] <= data_input;
    else if (do_repl) mem[idx_top]  <= data_input;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q  <= '0;
      dout_q <= '0;
    end else if (do_push) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      dout_q <= data_input;
    end else if (do_repl) begin
      dout_q <= data_input;
    end else if (do_pop) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      dout_q <= (cnt_q >= CNT_W'(2)) ? mem[idx_below] : '0;
    end
  end

  assign data_output = dout_q;
  assign count       = cnt_q;
  assign is_empty    = empty;
  assign is_full     = full;

`ifdef PARAM_STACK_ERR_EN
  logic ovf_q, unf_q;

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push_refused)   ovf_q <= 1'b1;
      else if (err_clear) ovf_q <= 1'b0;
      if (pop_refused)    unf_q <= 1'b1;
      else if (err_clear) unf_q <= 1'b0;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_err;
  assign unused_err = err_clear ^ push_refused ^ pop_refused;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule
